// File: rtl/img_pkg.sv
// Shared types and constants for the image BRAM pixel reader and writer.
package img_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [31:0] bram_word_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int FIFO_DEPTH     = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} rd_state_t;

  // Number of BRAM words needed to hold a given pixel count (last word may be partial).
  function automatic int words_for(input int pixels);
    return (pixels + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry 32-bit word FIFO with combinational head; push and pop in one clk is allowed.
module word_fifo2
  import img_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  bram_word_t push_data,
  input  logic       pop,
  output logic [1:0] count,
  output bram_word_t head
);

  bram_word_t mem_reg [FIFO_DEPTH];
  logic       rd_ptr_reg;
  logic       wr_ptr_reg;
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count_reg != 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same clk.
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/read_module.sv
// Fetches packed 32-bit words from BRAM and unpacks them little-endian into a valid/ready
// 8-bit pixel stream, keeping at most two words buffered or in flight.
module read_module
  import img_pkg::*;
#(
  parameter logic [31:0] INPUT_ADDR   = 32'h0000_0000,
  parameter int          NUM_PIXELS   = 784,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] bram_addr,
  output logic        bram_en,
  input  bram_word_t  bram_data,
  output pixel_t      pixel_o,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        busy,
  output logic        image_done
);

  localparam logic [29:0] NUM_WORDS  = 30'(words_for(NUM_PIXELS));
  localparam logic [31:0] LAST_PIXEL = 32'(NUM_PIXELS - 1);

  rd_state_t               state_reg, state_next;
  logic [29:0]             words_issued_reg;
  logic [31:0]             pixel_cnt_reg;
  logic [1:0]              byte_idx_reg;
  logic [1:0]              inflight_reg;
  logic [READ_LATENCY-1:0] pipe_reg;
  logic [READ_LATENCY-1:0] pipe_next;
  logic [1:0]              fifo_count;
  bram_word_t              fifo_head;
  logic [2:0]              credit_used;
  logic                    accept, issue, pipe_exit, xfer, last_pixel, pop;

  assign accept      = (state_reg == IDLE) && start;
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_reg};
  // Credit rule: a word is only requested when its FIFO slot is already guaranteed.
  assign issue       = (state_reg == RUN) && (words_issued_reg < NUM_WORDS) && (credit_used < 3'd2);
  assign pipe_exit   = pipe_reg[READ_LATENCY-1];
  assign pixel_valid = (fifo_count != 2'd0);
  assign xfer        = pixel_valid && pixel_ready;
  assign last_pixel  = (pixel_cnt_reg == LAST_PIXEL);
  assign pop         = xfer && ((byte_idx_reg == 2'd3) || last_pixel);

  assign bram_en   = issue;
  assign bram_addr = INPUT_ADDR + {words_issued_reg, 2'b00};
  assign pixel_o   = pixel_valid ? fifo_head[8*byte_idx_reg +: 8] : '0;

  // Read tags travel alongside the BRAM latency so the data is captured exactly when valid.
  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_next[gi] = issue;
      end else begin : g_tail
        assign pipe_next[gi] = pipe_reg[gi-1];
      end
    end
  endgenerate

  word_fifo2 u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pipe_exit),
    .push_data (bram_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      words_issued_reg <= '0;
      pixel_cnt_reg    <= '0;
      byte_idx_reg     <= '0;
      inflight_reg     <= '0;
      pipe_reg         <= '0;
    end else begin
      state_reg    <= state_next;
      pipe_reg     <= pipe_next;
      inflight_reg <= inflight_reg + {1'b0, issue} - {1'b0, pipe_exit};
      if (accept) begin
        words_issued_reg <= '0;
        pixel_cnt_reg    <= '0;
        byte_idx_reg     <= '0;
      end else begin
        if (issue) begin
          words_issued_reg <= words_issued_reg + 30'd1;
        end
        if (xfer) begin
          pixel_cnt_reg <= pixel_cnt_reg + 32'd1;
          byte_idx_reg  <= byte_idx_reg + 2'd1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    image_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (xfer && last_pixel) state_next = DONE;
      end
      DONE: begin
        image_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_read_module.sv
// Bench for read_module: four instances (8/6/784/16 pixels, latency 1/1/1/3) fed by BRAM models.
`timescale 1ns/1ps
module tb_read_module;

  localparam logic [127:0] NP_T   = {32'd16, 32'd784, 32'd6, 32'd8};
  localparam logic [127:0] LAT_T  = {32'd3, 32'd1, 32'd1, 32'd1};
  localparam logic [127:0] BASE_T = {32'h0000_0400, 32'h0000_1000, 32'h0000_0200, 32'h0000_0000};

  logic        clk = 1'b0;
  logic        reset;
  logic        start       [4];
  logic        pixel_ready [4];
  logic        bram_en     [4];
  logic        pixel_valid [4];
  logic        busy        [4];
  logic        image_done  [4];
  logic [31:0] bram_addr   [4];
  logic [31:0] bram_data   [4];
  logic [7:0]  pixel_o     [4];
  logic [31:0] mem [4][256];

  int compared   = 0;
  int mismatched = 0;

  // Observations gathered by run_image for the test tasks to judge.
  logic [7:0]  got[$];
  logic [31:0] addrs[$];
  int first_en, first_valid, first_xfer, last_xfer, done_cyc, done_cnt;
  int stab_err, max_out, busy_after_done;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int LAT = int'(LAT_T[gi*32 +: 32]);
      localparam int NP  = int'(NP_T[gi*32 +: 32]);
      logic [31:0] dpipe [3];

      read_module #(
        .INPUT_ADDR   (BASE_T[gi*32 +: 32]),
        .NUM_PIXELS   (NP),
        .READ_LATENCY (LAT)
      ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start[gi]),
        .bram_addr   (bram_addr[gi]),
        .bram_en     (bram_en[gi]),
        .bram_data   (bram_data[gi]),
        .pixel_o     (pixel_o[gi]),
        .pixel_valid (pixel_valid[gi]),
        .pixel_ready (pixel_ready[gi]),
        .busy        (busy[gi]),
        .image_done  (image_done[gi])
      );

      // BRAM model: data only meaningful exactly LAT clks after an enabled read.
      always @(posedge clk) begin
        dpipe[0] <= bram_en[gi] ? mem[gi][8'((bram_addr[gi] - BASE_T[gi*32 +: 32]) >> 2)] : 32'hDEAD_BEEF;
        dpipe[1] <= dpipe[0];
        dpipe[2] <= dpipe[1];
      end
      assign bram_data[gi] = dpipe[LAT-1];
    end
  endgenerate

  function automatic int np_of(input int g);
    return int'(NP_T[g*32 +: 32]);
  endfunction

  function automatic logic [31:0] base_of(input int g);
    return BASE_T[g*32 +: 32];
  endfunction

  // Reference: pixel k is byte (k mod 4) of word k/4, least significant byte first.
  function automatic logic [7:0] exp_pix(input int g, input int k);
    logic [31:0] w;
    w = mem[g][k/4];
    return w[8*(k%4) +: 8];
  endfunction

  function automatic int stream_errors(input int g, input int n);
    int errs;
    errs = 0;
    if (got.size() < n) return n;
    for (int k = 0; k < n; k++) if (got[k] !== exp_pix(g, k)) errs++;
    return errs;
  endfunction

  function automatic int addr_errors(input int g);
    int errs;
    errs = 0;
    foreach (addrs[i]) if (addrs[i] !== base_of(g) + 32'(4*i)) errs++;
    return errs;
  endfunction

  task automatic fill_random(input int g);
    for (int i = 0; i < 256; i++) mem[g][i] = $urandom;
  endtask

  // mode: 0 ready always, 1 ready toggles, 2 ready random.
  task automatic run_image(input int g, input int mode, input int restart_at,
                           input int abort_at, input bit start_on_done);
    int issued, popped, xfers, tail;
    bit prev_stall, restart_next, r;
    logic [7:0] prev_pix;
    issued = 0; popped = 0; xfers = 0; tail = -1;
    prev_stall = 0; restart_next = 0; prev_pix = 0;
    got.delete(); addrs.delete();
    first_en = -1; first_valid = -1; first_xfer = -1; last_xfer = -1; done_cyc = -1;
    done_cnt = 0; stab_err = 0; max_out = 0; busy_after_done = 0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      if (abort_at > 0 && xfers == abort_at) begin
        reset = 1'b0;
        pixel_ready[g] = 1'b0;
        start[g] = 1'b0;
        break;
      end
      start[g] = (cyc == 0) || restart_next || (start_on_done && image_done[g]);
      restart_next = 0;
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      pixel_ready[g] = r;
      if (bram_en[g]) begin
        issued++;
        addrs.push_back(bram_addr[g]);
        if (first_en < 0) first_en = cyc;
      end
      if (image_done[g]) begin
        done_cnt++;
        done_cyc = cyc;
        if (tail < 0) tail = 4;
      end else if (done_cnt > 0 && busy[g]) begin
        busy_after_done++;
      end
      if (pixel_valid[g]) begin
        if (prev_stall && pixel_o[g] !== prev_pix) stab_err++;
        if (first_valid < 0) first_valid = cyc;
      end else if (prev_stall) begin
        stab_err++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      prev_stall = pixel_valid[g] && !r;
      prev_pix = pixel_o[g];
      if (pixel_valid[g] && r) begin
        got.push_back(pixel_o[g]);
        xfers++;
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        if (xfers % 4 == 0 || xfers == np_of(g)) popped++;
        if (xfers == restart_at) restart_next = 1;
      end
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    start[g] = 1'b0;
    pixel_ready[g] = 1'b0;
    $display("image inst=%0d mode=%0d pixels=%0d reads=%0d done=%0d", g, mode, got.size(), addrs.size(), done_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      compared += 6;
      if (bram_addr[g] !== base_of(g)) begin mismatched++; $display("FAIL rst_addr[%0d]: got %h want %h", g, bram_addr[g], base_of(g)); end
      if (bram_en[g] !== 1'b0) begin mismatched++; $display("FAIL rst_en[%0d]: got %b want 0", g, bram_en[g]); end
      if (pixel_o[g] !== 8'h00) begin mismatched++; $display("FAIL rst_pix[%0d]: got %h want 00", g, pixel_o[g]); end
      if (pixel_valid[g] !== 1'b0) begin mismatched++; $display("FAIL rst_valid[%0d]: got %b want 0", g, pixel_valid[g]); end
      if (busy[g] !== 1'b0) begin mismatched++; $display("FAIL rst_busy[%0d]: got %b want 0", g, busy[g]); end
      if (image_done[g] !== 1'b0) begin mismatched++; $display("FAIL rst_done[%0d]: got %b want 0", g, image_done[g]); end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    mem[0][0] = 32'h0403_0201;
    mem[0][1] = 32'h0807_0605;
    run_image(0, 0, 0, 0, 0);
    compared++;
    if (got.size() != 8) begin mismatched++; $display("FAIL t1_len: got %0d want 8", got.size()); end
    compared++;
    if (stream_errors(0, 8) != 0) begin mismatched++; $display("FAIL t1_stream: got %0d bad want 0", stream_errors(0, 8)); end
    compared++;
    if (got.size() == 8 && (got[0] !== 8'h01 || got[7] !== 8'h08)) begin
      mismatched++; $display("FAIL t1_ends: got %h..%h want 01..08", got[0], got[7]);
    end
    compared++;
    if (addrs.size() != 2 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4) begin
      mismatched++; $display("FAIL t1_addr: got %0d reads want 0x0,0x4", addrs.size());
    end
    compared++;
    if (last_xfer - first_xfer != 7) begin mismatched++; $display("FAIL t1_span: got %0d want 7", last_xfer - first_xfer); end
    compared++;
    if (done_cnt != 1 || done_cyc != last_xfer + 1) begin
      mismatched++; $display("FAIL t1_done: got cnt %0d at %0d want 1 at %0d", done_cnt, done_cyc, last_xfer + 1);
    end
    compared++;
    if (first_en != 1 || first_valid != 3) begin
      mismatched++; $display("FAIL t1_latency: got en@%0d valid@%0d want en@1 valid@3", first_en, first_valid);
    end
  endtask

  task automatic test_partial();
    logic [7:0] exp6 [6];
    int bad;
    exp6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    mem[1][0] = 32'hDDCC_BBAA;
    mem[1][1] = 32'h4433_2211;
    mem[1][2] = 32'h5A5A_5A5A;
    run_image(1, 0, 0, 0, 0);
    bad = 0;
    for (int k = 0; k < 6; k++) if (k >= got.size() || got[k] !== exp6[k]) bad++;
    compared++;
    if (got.size() != 6 || bad != 0) begin mismatched++; $display("FAIL t2_stream: got %0d px %0d bad want 6 px 0 bad", got.size(), bad); end
    compared++;
    if (addrs.size() != 2 || addr_errors(1) != 0) begin mismatched++; $display("FAIL t2_reads: got %0d want 2", addrs.size()); end
    compared++;
    if (done_cnt != 1 || done_cyc != last_xfer + 1) begin mismatched++; $display("FAIL t2_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    fill_random(2);
    run_image(2, 1, 0, 0, 0);
    compared++;
    if (got.size() != 784 || stream_errors(2, 784) != 0) begin
      mismatched++; $display("FAIL t3_stream: got %0d px %0d bad want 784 px 0 bad", got.size(), stream_errors(2, 784));
    end
    compared++;
    if (stab_err != 0) begin mismatched++; $display("FAIL t3_stable: got %0d unstable clks want 0", stab_err); end
    compared++;
    if (max_out > 2) begin mismatched++; $display("FAIL t3_credit: got %0d outstanding want <=2", max_out); end
    compared++;
    if (addrs.size() != 196 || addr_errors(2) != 0) begin
      mismatched++; $display("FAIL t3_addr: got %0d reads %0d bad want 196 reads 0 bad", addrs.size(), addr_errors(2));
    end
    compared++;
    if (done_cnt != 1) begin mismatched++; $display("FAIL t3_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_latency3();
    int bad4;
    fill_random(3);
    run_image(3, 0, 0, 0, 0);
    compared++;
    if (got.size() != 16 || stream_errors(3, 16) != 0) begin
      mismatched++; $display("FAIL t4_stream: got %0d px %0d bad want 16 px 0 bad", got.size(), stream_errors(3, 16));
    end
    bad4 = 0;
    for (int k = 0; k < 4; k++) if (k >= got.size() || got[k] !== exp_pix(3, k)) bad4++;
    compared++;
    if (bad4 != 0) begin mismatched++; $display("FAIL t4_first_word: got %0d bad want 0", bad4); end
    compared++;
    if (last_xfer - first_xfer != 15) begin mismatched++; $display("FAIL t4_gaps: got span %0d want 15", last_xfer - first_xfer); end
    compared++;
    if (first_en != 1 || first_valid != 5) begin
      mismatched++; $display("FAIL t4_latency: got en@%0d valid@%0d want en@1 valid@5", first_en, first_valid);
    end
  endtask

  task automatic test_restart_ignored();
    fill_random(2);
    run_image(2, 0, 100, 0, 1);
    compared++;
    if (got.size() != 784 || stream_errors(2, 784) != 0) begin
      mismatched++; $display("FAIL t5_stream: got %0d px want 784", got.size());
    end
    compared++;
    if (done_cnt != 1 || done_cyc != last_xfer + 1) begin mismatched++; $display("FAIL t5_done: got %0d want 1", done_cnt); end
    compared++;
    if (addrs.size() != 196) begin mismatched++; $display("FAIL t5_reads: got %0d want 196", addrs.size()); end
    compared++;
    if (busy_after_done != 0) begin mismatched++; $display("FAIL t5_start_at_done: got %0d busy clks want 0", busy_after_done); end
  endtask

  task automatic test_abort();
    int late_done;
    fill_random(2);
    run_image(2, 2, 0, 300, 0);
    compared++;
    if (got.size() != 300 || stream_errors(2, 300) != 0) begin
      mismatched++; $display("FAIL t6_partial: got %0d px want 300", got.size());
    end
    #1;
    compared += 6;
    if (bram_addr[2] !== base_of(2)) begin mismatched++; $display("FAIL t6_rst_addr: got %h want %h", bram_addr[2], base_of(2)); end
    if (bram_en[2] !== 1'b0) begin mismatched++; $display("FAIL t6_rst_en: got %b want 0", bram_en[2]); end
    if (pixel_o[2] !== 8'h00) begin mismatched++; $display("FAIL t6_rst_pix: got %h want 00", pixel_o[2]); end
    if (pixel_valid[2] !== 1'b0) begin mismatched++; $display("FAIL t6_rst_valid: got %b want 0", pixel_valid[2]); end
    if (busy[2] !== 1'b0) begin mismatched++; $display("FAIL t6_rst_busy: got %b want 0", busy[2]); end
    if (image_done[2] !== 1'b0) begin mismatched++; $display("FAIL t6_rst_done: got %b want 0", image_done[2]); end
    late_done = done_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (image_done[2] || pixel_valid[2]) late_done++;
    end
    compared++;
    if (late_done != 0) begin mismatched++; $display("FAIL t6_no_done: got %0d want 0", late_done); end
    fill_random(2);
    run_image(2, 0, 0, 0, 0);
    compared++;
    if (addrs.size() == 0 || addrs[0] !== base_of(2)) begin mismatched++; $display("FAIL t6_restart_addr: got %0d reads want first at base", addrs.size()); end
    compared++;
    if (got.size() != 784 || stream_errors(2, 784) != 0) begin
      mismatched++; $display("FAIL t6_restart_stream: got %0d px want 784", got.size());
    end
    compared++;
    if (done_cnt != 1) begin mismatched++; $display("FAIL t6_restart_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    reset = 1'b0;
    for (int g = 0; g < 4; g++) begin
      start[g] = 1'b0;
      pixel_ready[g] = 1'b0;
      for (int i = 0; i < 256; i++) mem[g][i] = '0;
    end
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_latency3();
    test_restart_ignored();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
